uart_rx_byte: RTL and testbench

Receives 8N1 asynchronous serial bytes from a line that has already passed through the two-flop input synchronizer. It sits directly downstream of that synchronizer and feeds received bytes to the 65C02 I/O register file through a one-entry valid/ready holding register. It flags framing errors, overruns and, optionally, parity errors.

---
 rtl/uart_rx_byte.sv | 157 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit after data bit 7 and drive parity_err.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868,
  localparam int CW = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sync,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic [2:0] state_dbg
);

  // Handshake: rx_valid rises with rx_data and both hold until an edge with
  // rx_valid & rx_ready; rx_ready is ignored while rx_valid is low.

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY  = 3'd3;
`endif
  localparam logic [2:0] STOP    = 3'd4;
  localparam logic [2:0] RECOVER = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_bad = par_bit != (^shift);
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // An accept drains the register; a delivery later in this block wins.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_sync) state <= START;
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (rx_sync) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              idx   <= 3'd0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shift[idx] <= rx_sync;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_bit <= rx_sync;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (!rx_sync) begin
              frame_err <= 1'b1;
              state     <= RECOVER;
            end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              parity_err <= 1'b1;
`endif
              state <= IDLE;
            end else begin
              state <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECOVER: begin
          // A held-low break stays here so it cannot restart as fresh frames.
          cnt <= '0;
          if (rx_sync) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: self-checking bench for uart_rx_byte at CLKS_PER_BIT=16.
// Frames carry a parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx_byte;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int STOP_OFF = HALF + (NBITS - 1) * CPB;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_RECOVER = 3'd5;

  logic       clk;
  logic       rst;
  logic       rx_sync;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_sync    (rx_sync),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // driver: called at a negedge; the DUT sees the start bit on the next posedge (T0)
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic flip_par, input int hold_low);
    rx_sync = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_sync = data[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_sync = (^data) ^ flip_par;
    repeat (CPB) @(negedge clk);
`else
    if (flip_par) $display("note: parity flip ignored without parity");
`endif
    rx_sync = stop_bit;
    repeat (CPB) @(negedge clk);
    if (hold_low > 0) begin
      rx_sync = 1'b0;
      repeat (hold_low) @(negedge clk);
    end
    rx_sync = 1'b1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard: a transfer happens on the posedge following a negedge with valid & ready
  always @(negedge clk) begin
    #1;
    if (!rst && rx_valid && rx_ready) begin
      check("q_has_exp", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rx_data", rx_data, exp_q.pop_front());
    end
    if (frame_err) fe_cnt++;
  end

  initial begin
    logic [7:0] d;
    int fe0;
    rst      = 1'b1;
    rx_sync  = 1'b1;
    rx_ready = 1'b0;
    edges(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_perr", parity_err, 0);
    check("rst_state", state_dbg, S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // single byte, consumer ready
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    fork send_frame(8'hA5, 1'b1, 1'b0, 0); join_none
    edges(1);
    edges(STOP_OFF - 1);
    check("a5_early_valid", rx_valid, 0);
    edges(1);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_ferr", frame_err, 0);
    check("a5_ovr", overrun, 0);
    check("a5_perr", parity_err, 0);
    edges(1);
    check("a5_valid_clr", rx_valid, 0);
    wait fork;
    idle(4);

    // 3-cycle glitch rejected at T0+HALF
    fork begin rx_sync = 1'b0; repeat (3) @(negedge clk); rx_sync = 1'b1; end join_none
    edges(1);
    edges(HALF - 1);
    check("glitch_start", state_dbg, S_START);
    edges(1);
    check("glitch_idle", state_dbg, S_IDLE);
    check("glitch_valid", rx_valid, 0);
    wait fork;
    idle(4);

    // low stop bit followed by a held-low line
    fe0 = fe_cnt;
    fork send_frame(8'h3C, 1'b0, 1'b0, 40); join_none
    edges(1);
    edges(STOP_OFF - 1);
    check("fe_early", frame_err, 0);
    edges(1);
    check("fe_pulse", frame_err, 1);
    check("fe_valid", rx_valid, 0);
    check("fe_recover", state_dbg, S_RECOVER);
    edges(1);
    check("fe_drop", frame_err, 0);
    wait fork;
    idle(30);
    check("fe_count", fe_cnt - fe0, 1);
    check("fe_idle", state_dbg, S_IDLE);

    // overrun: two frames back-to-back while the consumer stalls
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    fork begin
      send_frame(8'h11, 1'b1, 1'b0, 0);
      send_frame(8'h22, 1'b1, 1'b0, 0);
    end join_none
    edges(1);
    edges(STOP_OFF);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_data", rx_data, 8'h11);
    check("ovr_first_flag", overrun, 0);
    edges(NBITS * CPB - 1);
    check("ovr_before", overrun, 0);
    edges(1);
    check("ovr_set", overrun, 1);
    check("ovr_held_data", rx_data, 8'h11);
    check("ovr_held_valid", rx_valid, 1);
    wait fork;
    rx_ready = 1'b1;
    edges(1);
    check("ovr_valid_clr", rx_valid, 0);
    check("ovr_clr", overrun, 0);
    idle(4);

    // asynchronous reset mid-frame
    rx_ready = 1'b0;
    fork send_frame(8'h81, 1'b1, 1'b0, 0); join_none
    wait fork;
    idle(2);
    check("pre_rst_valid", rx_valid, 1);
    check("pre_rst_data", rx_data, 8'h81);
    fork send_frame(8'hC3, 1'b1, 1'b0, 0); join_none
    edges(1);
    repeat (59) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", rx_valid, 0);
    check("arst_data", rx_data, 0);
    check("arst_state", state_dbg, S_IDLE);
    check("arst_ovr", overrun, 0);
    wait fork;
    idle(2);
    rst = 1'b0;
    idle(3);
    rx_ready = 1'b1;
    exp_q.push_back(8'h5A);
    fork send_frame(8'h5A, 1'b1, 1'b0, 0); join_none
    wait fork;
    idle(5);

    // random bytes back-to-back with the consumer always ready
    fork begin
      for (int i = 0; i < 4; i++) begin
        d = 8'($urandom_range(0, 255));
        exp_q.push_back(d);
        send_frame(d, 1'b1, 1'b0, 0);
      end
    end join_none
    wait fork;
    idle(5);

`ifdef UART_RX_PARITY_EN
    fork send_frame(8'h07, 1'b1, 1'b1, 0); join_none
    edges(1);
    edges(STOP_OFF - 1);
    check("par_early", parity_err, 0);
    edges(1);
    check("par_pulse", parity_err, 1);
    check("par_valid", rx_valid, 0);
    edges(1);
    check("par_drop", parity_err, 0);
    wait fork;
    idle(4);
    exp_q.push_back(8'h07);
    fork send_frame(8'h07, 1'b1, 1'b0, 0); join_none
    wait fork;
    idle(5);
`endif

    idle(20);
    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
